// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch controller: FSM state encoding and parameter defaults.
package cpu_pkg;

    localparam int unsigned PC_W_DEF    = 8;
    localparam int unsigned INSTR_W_DEF = 16;
    localparam int unsigned PC_INCR_DEF = 4;
    localparam logic [7:0]  RESET_PC_DEF = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_FETCH   = 2'b01,
        ST_DELIVER = 2'b10,
        ST_HALTED  = 2'b11
    } state_e;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Bundle of instruction-memory, decode and control signals around the fetch controller.
interface pc_fetch_ctrl_if #(
    parameter int unsigned PC_W    = cpu_pkg::PC_W_DEF,
    parameter int unsigned INSTR_W = cpu_pkg::INSTR_W_DEF
);

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               halt_req;
    logic               halted;

    // Controller side.
    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, halted,
        input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc, halt_req
    );

    // Memory / decode / control side.
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, halted,
        output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc, halt_req
    );

endinterface

// File: rtl/pc_fetch_ctrl_pc_incr.sv
// Sequential PC step: PC_W-bit add with wrap, carry dropped.
module pc_incr
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W    = PC_W_DEF,
    parameter int unsigned PC_INCR = PC_INCR_DEF
) (
    input  logic [PC_W-1:0] pc_i,
    output logic [PC_W-1:0] pc_next_o
);

    assign pc_next_o = pc_i + PC_W'(PC_INCR);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: request/ack memory fetch, valid/ready delivery to decode,
// with branch redirect and halt handling.
module pc_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = PC_W_DEF,
    parameter int unsigned     INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
    parameter int unsigned     PC_INCR  = PC_INCR_DEF
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_ctrl_if.master bus
);

    state_e             state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    target_q;
    logic [PC_W-1:0]    instr_pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic               halt_pend_q;
    logic               redir_pend_q;
    logic [PC_W-1:0]    pc_inc;

    pc_incr #(
        .PC_W    (PC_W),
        .PC_INCR (PC_INCR)
    ) u_pc_incr (
        .pc_i      (pc_q),
        .pc_next_o (pc_inc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            target_q     <= RESET_PC;
            instr_pc_q   <= '0;
            instr_q      <= '0;
            halt_pend_q  <= 1'b0;
            redir_pend_q <= 1'b0;
        end else begin
            if (bus.halt_req && (state_q != ST_HALTED)) begin
                halt_pend_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.redirect_valid) begin
                        pc_q <= bus.redirect_pc;
                    end
                    state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    // A redirect seen during the fetch kills the returning data.
                    if (bus.imem_ack) begin
                        if (redir_pend_q || bus.redirect_valid) begin
                            pc_q         <= bus.redirect_valid ? bus.redirect_pc : target_q;
                            redir_pend_q <= 1'b0;
                        end else begin
                            instr_q    <= bus.imem_rdata;
                            instr_pc_q <= pc_q;
                            state_q    <= ST_DELIVER;
                        end
                    end else if (bus.redirect_valid) begin
                        redir_pend_q <= 1'b1;
                        target_q     <= bus.redirect_pc;
                    end
                end
                ST_DELIVER: begin
                    if (bus.redirect_valid) begin
                        pc_q    <= bus.redirect_pc;
                        state_q <= ST_FETCH;
                    end else if (bus.instr_ready) begin
                        pc_q <= pc_inc;
                        if (halt_pend_q || bus.halt_req) begin
                            halt_pend_q <= 1'b0;
                            state_q     <= ST_HALTED;
                        end else begin
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_HALTED: begin
                    if (bus.redirect_valid) begin
                        pc_q    <= bus.redirect_pc;
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode straight from registered state, so reset takes effect without a clock.
    assign bus.imem_req    = (state_q == ST_FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (state_q == ST_DELIVER);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.halted      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: sequential fetch, stall, redirects, wrap, halt and async reset.
module tb_pc_fetch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl_if bus_if ();

    pc_fetch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    function automatic logic [15:0] instr_of(input logic [7:0] a);
        return {a ^ 8'hC3, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in FETCH at address a with instr_ready=1: ack, see delivery, accept.
    task automatic do_fetch(input logic [7:0] a);
        chk("fetch_req", 32'(bus_if.imem_req), 32'd1);
        chk("fetch_addr", 32'(bus_if.imem_addr), 32'(a));
        bus_if.imem_ack   = 1'b1;
        bus_if.imem_rdata = instr_of(a);
        step();
        bus_if.imem_ack   = 1'b0;
        chk("deliver_valid", 32'(bus_if.instr_valid), 32'd1);
        chk("deliver_req", 32'(bus_if.imem_req), 32'd0);
        chk("deliver_instr", 32'(bus_if.instr), 32'(instr_of(a)));
        chk("deliver_pc", 32'(bus_if.instr_pc), 32'(a));
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        step();
        rst = 1'b0;
        chk("idle_req", 32'(bus_if.imem_req), 32'd0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.imem_ack       = 1'b0;
        bus_if.imem_rdata     = '0;
        bus_if.instr_ready    = 1'b1;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = '0;
        bus_if.halt_req       = 1'b0;

        // Reset values.
        #3;
        chk("rst_req", 32'(bus_if.imem_req), 32'd0);
        chk("rst_addr", 32'(bus_if.imem_addr), 32'h00);
        chk("rst_valid", 32'(bus_if.instr_valid), 32'd0);
        chk("rst_instr", 32'(bus_if.instr), 32'd0);
        chk("rst_instr_pc", 32'(bus_if.instr_pc), 32'd0);
        chk("rst_halted", 32'(bus_if.halted), 32'd0);

        // Release reset: one IDLE cycle, then FETCH; sequential addresses.
        step();
        rst = 1'b0;
        chk("idle_req", 32'(bus_if.imem_req), 32'd0);
        step();
        do_fetch(8'h00);
        do_fetch(8'h04);
        do_fetch(8'h08);
        do_fetch(8'h0C);

        // Halt during DELIVER at 0x10 with same-cycle accept.
        chk("h_req", 32'(bus_if.imem_req), 32'd1);
        chk("h_addr", 32'(bus_if.imem_addr), 32'h10);
        bus_if.imem_ack   = 1'b1;
        bus_if.imem_rdata = instr_of(8'h10);
        step();
        bus_if.imem_ack = 1'b0;
        chk("h_valid", 32'(bus_if.instr_valid), 32'd1);
        bus_if.halt_req = 1'b1;
        step();
        bus_if.halt_req = 1'b0;
        chk("h_halted", 32'(bus_if.halted), 32'd1);
        chk("h_req0", 32'(bus_if.imem_req), 32'd0);
        chk("h_valid0", 32'(bus_if.instr_valid), 32'd0);
        step();
        step();
        chk("h_stay_halted", 32'(bus_if.halted), 32'd1);
        chk("h_stay_req0", 32'(bus_if.imem_req), 32'd0);
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 8'h20;
        step();
        bus_if.redirect_valid = 1'b0;
        chk("h_unhalt", 32'(bus_if.halted), 32'd0);
        do_fetch(8'h20);

        // Stall: ack withheld three cycles at 0x04.
        do_reset();
        do_fetch(8'h00);
        for (int i = 0; i < 3; i++) begin
            chk("stall_req", 32'(bus_if.imem_req), 32'd1);
            chk("stall_addr", 32'(bus_if.imem_addr), 32'h04);
            chk("stall_valid", 32'(bus_if.instr_valid), 32'd0);
            step();
        end
        do_fetch(8'h04);

        // Redirect during FETCH at 0x08 before ack: data dropped, next request 0x40.
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 8'h40;
        step();
        bus_if.redirect_valid = 1'b0;
        chk("rf_hold_req", 32'(bus_if.imem_req), 32'd1);
        chk("rf_hold_addr", 32'(bus_if.imem_addr), 32'h08);
        bus_if.imem_ack   = 1'b1;
        bus_if.imem_rdata = instr_of(8'h08);
        step();
        bus_if.imem_ack = 1'b0;
        chk("rf_no_valid", 32'(bus_if.instr_valid), 32'd0);
        do_fetch(8'h40);

        // Redirect in the same cycle as ack at 0x44: data dropped.
        bus_if.imem_ack       = 1'b1;
        bus_if.imem_rdata     = instr_of(8'h44);
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 8'h80;
        step();
        bus_if.imem_ack       = 1'b0;
        bus_if.redirect_valid = 1'b0;
        chk("rs_no_valid", 32'(bus_if.instr_valid), 32'd0);
        do_fetch(8'h80);

        // Redirect in DELIVER to 0xFC, then wrap to 0x00.
        bus_if.imem_ack   = 1'b1;
        bus_if.imem_rdata = instr_of(8'h84);
        step();
        bus_if.imem_ack       = 1'b0;
        chk("rd_valid", 32'(bus_if.instr_valid), 32'd1);
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 8'hFC;
        step();
        bus_if.redirect_valid = 1'b0;
        chk("rd_drop_valid", 32'(bus_if.instr_valid), 32'd0);
        do_fetch(8'hFC);
        do_fetch(8'h00);
        do_fetch(8'h04);
        do_fetch(8'h08);

        // Async reset mid-request at 0x0C.
        chk("ar_req", 32'(bus_if.imem_req), 32'd1);
        chk("ar_addr", 32'(bus_if.imem_addr), 32'h0C);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_req0", 32'(bus_if.imem_req), 32'd0);
        chk("ar_addr0", 32'(bus_if.imem_addr), 32'h00);
        chk("ar_instr0", 32'(bus_if.instr), 32'd0);
        step();
        rst = 1'b0;
        bus_if.imem_ack   = 1'b1;
        bus_if.imem_rdata = instr_of(8'h0C);
        step();
        bus_if.imem_ack = 1'b0;
        chk("ar_ack_ignored", 32'(bus_if.instr_valid), 32'd0);
        do_fetch(8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
